data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 119 +++++++++++
 tb/tb_data_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder: accepts one read or write from IDLE,
// completes it LATENCY+1 cycles later with a one-cycle ready pulse.
module data_mem_responder #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        stall,
   output logic        err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            op_wr_q, op_wr_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            ready_q, ready_d;
   logic            err_q, err_d;
   logic            mem_we_c;
   logic            req_c;
   logic            bad_c;
   logic            unused_c;
   logic [31:0]     mem_q [DEPTH];

   assign req_c    = (memRead ^ memWrite) && (addr[1:0] == 2'b00);
   assign bad_c    = (memRead && memWrite) || ((memRead || memWrite) && (addr[1:0] != 2'b00));
   assign unused_c = ^addr[31:AW+2];

   assign rdata = rdata_q;
   assign ready = ready_q;
   assign err   = err_q;
   // Hold the datapath while a request is pending; release on the ready cycle.
   assign stall = ((state_q == IDLE) && (req_c || bad_c)) || (state_q == BUSY);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_wr_d  = op_wr_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      ready_d  = 1'b0;
      err_d    = 1'b0;
      mem_we_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bad_c) begin
               state_d = DONE;
               ready_d = 1'b1;
               err_d   = 1'b1;
            end else if (req_c) begin
               op_wr_d = memWrite;
               idx_d   = addr[AW+1:2];
               wdata_d = wdata;
               cnt_d   = CW'(LATENCY - 1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d = DONE;
               ready_d = 1'b1;
               if (op_wr_q) begin
                  mem_we_c = 1'b1;
               end else begin
                  rdata_d = mem_q[idx_q];
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   // Array contents survive reset; a reset in BUSY drops the write enable.
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder against a
// transaction-level model (pending countdown plus word array).
module tb_data_mem_responder;

   localparam int unsigned DEPTH   = 256;
   localparam int unsigned LATENCY = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        memRead, memWrite;
   logic [31:0] addr, wdata, rdata;
   logic        ready, stall, err;

   int n_checks = 0;
   int n_errors = 0;

   data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
      .stall(stall), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a pending transaction completes a fixed number of
   // cycles after it is seen; the array is updated on completion.
   logic [31:0] m_mem [DEPTH];
   bit          m_known [DEPTH];
   logic [31:0] m_rdata = '0;
   bit          m_rd_known = 1'b0;
   bit          m_pend = 1'b0;
   int          m_rem = 0;
   bit          m_err, m_wr;
   int          m_idx;
   logic [31:0] m_wd;

   always @(negedge clk) begin
      bit rq, bd;
      rq = (memRead ^ memWrite) && (addr[1:0] == 2'b00);
      bd = (memRead && memWrite) || ((memRead || memWrite) && (addr[1:0] != 2'b00));
      if (!rst_n) begin
         m_pend     = 1'b0;
         m_rdata    = '0;
         m_rd_known = 1'b1;
         chk("rst_ready", 32'(ready), 32'(0));
         chk("rst_err", 32'(err), 32'(0));
         chk("rst_stall", 32'(stall), 32'(rq | bd));
      end else if (m_pend) begin
         m_rem--;
         if (m_rem == 0) begin
            if (!m_err) begin
               if (m_wr) begin
                  m_mem[m_idx]   = m_wd;
                  m_known[m_idx] = 1'b1;
               end else begin
                  m_rdata    = m_mem[m_idx];
                  m_rd_known = m_known[m_idx];
               end
            end
            chk("done_ready", 32'(ready), 32'(1));
            chk("done_err", 32'(err), 32'(m_err));
            chk("done_stall", 32'(stall), 32'(0));
            m_pend = 1'b0;
         end else begin
            chk("busy_ready", 32'(ready), 32'(0));
            chk("busy_err", 32'(err), 32'(0));
            chk("busy_stall", 32'(stall), 32'(1));
         end
      end else begin
         chk("idle_ready", 32'(ready), 32'(0));
         chk("idle_err", 32'(err), 32'(0));
         chk("idle_stall", 32'(stall), 32'(rq | bd));
         if (bd) begin
            m_pend = 1'b1;
            m_rem  = 1;
            m_err  = 1'b1;
         end else if (rq) begin
            m_pend = 1'b1;
            m_rem  = int'(LATENCY) + 1;
            m_err  = 1'b0;
            m_wr   = memWrite;
            m_idx  = int'((addr >> 2) & (DEPTH - 1));
            m_wd   = wdata;
         end
      end
      if (m_rd_known) chk("rdata", rdata, m_rdata);
   end

   task automatic set_in(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      memRead  = r;
      memWrite = w;
      addr     = a;
      wdata    = d;
   endtask

   task automatic wait_ready(output int lat, output int st, output logic e, output logic [31:0] rd);
      lat = 0;
      st  = 0;
      e   = 1'b0;
      rd  = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         lat++;
         if (ready) begin
            e  = err;
            rd = rdata;
            return;
         end
         if (stall) st++;
      end
      n_checks++;
      n_errors++;
      $display("FAIL wait_ready: no ready within 40 cycles at %0t", $time);
   endtask

   task automatic txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output int st, output logic e, output logic [31:0] rd);
      set_in(r, w, a, d);
      wait_ready(lat, st, e, rd);
   endtask

   initial begin
      int          lat, st;
      logic        e;
      logic [31:0] rd, a;
      int          sel;

      rst_n = 1'b0; memRead = 1'b0; memWrite = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      set_in(0, 0, 0, 0);

      // Write then read back, with latency and stall-count pinned.
      txn(0, 1, 32'h10, 32'hDEADBEEF, lat, st, e, rd);
      chk("wr10_lat", 32'(lat), 32'd4);
      chk("wr10_stall_cycles", 32'(st), 32'd3);
      chk("wr10_err", 32'(e), 32'd0);
      txn(1, 0, 32'h10, 0, lat, st, e, rd);
      chk("rd10_lat", 32'(lat), 32'd4);
      chk("rd10_data", rd, 32'hDEADBEEF);

      txn(0, 1, 32'h20, 32'hA5A5A5A5, lat, st, e, rd);
      // Index wraps modulo DEPTH.
      txn(0, 1, 32'h400, 32'h1, lat, st, e, rd);
      txn(1, 0, 32'h0, 0, lat, st, e, rd);
      chk("wrap_data", rd, 32'h00000001);

      // Read and write together: immediate error completion.
      txn(1, 1, 32'h20, 32'h12345678, lat, st, e, rd);
      chk("both_lat", 32'(lat), 32'd2);
      chk("both_err", 32'(e), 32'd1);
      chk("both_rdata_kept", rd, 32'h00000001);
      txn(1, 0, 32'h20, 0, lat, st, e, rd);
      chk("word20_intact", rd, 32'hA5A5A5A5);

      // Misaligned read.
      txn(1, 0, 32'h22, 0, lat, st, e, rd);
      chk("misal_lat", 32'(lat), 32'd2);
      chk("misal_err", 32'(e), 32'd1);
      chk("misal_rdata_kept", rd, 32'hA5A5A5A5);

      // Reset during BUSY discards the write.
      txn(0, 1, 32'h30, 32'h1234, lat, st, e, rd);
      set_in(0, 1, 32'h30, 32'h55);
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0; memWrite = 1'b0;
      @(negedge clk);
      chk("midrst_ready", 32'(ready), 32'd0);
      chk("midrst_rdata", rdata, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      txn(1, 0, 32'h30, 0, lat, st, e, rd);
      chk("rd30_after_rst", rd, 32'h1234);

      // Back-to-back reads held across DONE; address change in BUSY ignored.
      txn(0, 1, 32'h14, 32'hCAFEF00D, lat, st, e, rd);
      txn(1, 0, 32'h10, 0, lat, st, e, rd);
      chk("b2b_first", rd, 32'hDEADBEEF);
      @(negedge clk);
      chk("b2b_accept_stall", 32'(stall), 32'd1);
      @(posedge clk);
      #1 addr = 32'h14;
      wait_ready(lat, st, e, rd);
      chk("b2b_lat", 32'(lat), 32'd3);
      chk("b2b_second", rd, 32'hDEADBEEF);

      // Random traffic, inputs changing every cycle, occasional reset.
      for (int n = 0; n < 2000; n++) begin
         @(posedge clk);
         #1;
         rst_n = ($urandom_range(0, 199) != 0);
         a = 32'($urandom_range(0, 15)) << 2;
         if ($urandom_range(0, 3) == 0) a = a | (32'($urandom) & 32'hFFFF_FC00);
         if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
         sel      = int'($urandom_range(0, 9));
         memRead  = (sel <= 3) || (sel == 7);
         memWrite = (sel >= 4) && (sel <= 7);
         addr     = a;
         wdata    = 32'($urandom);
      end
      set_in(0, 0, 0, 0);
      #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
